// File: rtl/game_pkg.sv
// Shared state codes and helpers for the game sequencer and state-driven blocks.
package game_pkg;
  localparam int STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_TITLE    = 4'd0;
  localparam state_t ST_STAFF    = 4'd1;
  localparam state_t ST_STAGE1   = 4'd2;
  localparam state_t ST_CLEAR1   = 4'd3;
  localparam state_t ST_STAGE2   = 4'd4;
  localparam state_t ST_CLEAR2   = 4'd5;
  localparam state_t ST_STAGE3   = 4'd6;
  localparam state_t ST_ENDING   = 4'd7;
  localparam state_t ST_GAMEOVER = 4'd8;

  function automatic logic is_stage(input state_t s);
    return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
  endfunction

  function automatic logic is_clear(input state_t s);
    return (s == ST_CLEAR1) || (s == ST_CLEAR2);
  endfunction

  // Stage index 1..3 for STAGEn/CLEARn, 0 elsewhere.
  function automatic logic [1:0] stage_of(input state_t s);
    case (s)
      ST_STAGE1, ST_CLEAR1: return 2'd1;
      ST_STAGE2, ST_CLEAR2: return 2'd2;
      ST_STAGE3:            return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/hold_timer.sv
// Clear-screen dwell counter; done flags the last cycle of the hold.
module hold_timer #(
  parameter int CLEAR_HOLD_CYC = 200_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(CLEAR_HOLD_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(CLEAR_HOLD_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= r_cnt + CW'(1);
  end

  assign done = (r_cnt == LAST);
endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title, three stages with clear screens, ending/game-over.
// Optional stage time limit enabled by defining STAGE_TIMEOUT_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int CLEAR_HOLD_CYC = 200_000_000,
  parameter int TIMEOUT_MIN    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start,
  input  logic         btn_staff,
  input  logic         stage_clear,
  input  logic         player_dead,
  input  logic [15:0]  time_bcd,
  output logic [3:0]   state,
  output logic [1:0]   stage_num,
  output logic         stage_enter
);
  state_t r_state, w_nxt;
  logic   r_stage_enter;
  logic [1:0] r_stage_num;
  logic   w_in_clear, w_hold_done, w_timeout;

  assign w_in_clear = is_clear(r_state);

  hold_timer #(.CLEAR_HOLD_CYC(CLEAR_HOLD_CYC)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_in_clear),
    .en    (w_in_clear),
    .done  (w_hold_done)
  );

`ifdef STAGE_TIMEOUT_EN
  // The timer display can lag a fresh stage by up to 2 cycles, so hold off the check.
  logic [1:0] r_mask_cnt;
  logic [7:0] w_minutes;
  logic       w_unused_sec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_mask_cnt <= '0;
    else if (!is_stage(r_state)) r_mask_cnt <= '0;
    else if (r_mask_cnt != 2'd3) r_mask_cnt <= r_mask_cnt + 2'd1;
  end

  assign w_minutes    = 8'(time_bcd[15:12]) * 8'd10 + 8'(time_bcd[11:8]);
  assign w_timeout    = r_mask_cnt[1] && (w_minutes >= 8'(TIMEOUT_MIN));
  assign w_unused_sec = ^time_bcd[7:0];
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = ^{time_bcd, 8'(TIMEOUT_MIN)};
`endif

  // Each forward step (STAGEn->CLEARn/ENDING, CLEARn->STAGEn+1) is code+1.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_TITLE:
        if (btn_start)      w_nxt = ST_STAGE1;
        else if (btn_staff) w_nxt = ST_STAFF;
      ST_STAFF:
        if (btn_start || btn_staff) w_nxt = ST_TITLE;
      ST_STAGE1, ST_STAGE2, ST_STAGE3:
        if (player_dead)      w_nxt = ST_GAMEOVER;
        else if (w_timeout)   w_nxt = ST_GAMEOVER;
        else if (stage_clear) w_nxt = r_state + state_t'(1);
      ST_CLEAR1, ST_CLEAR2:
        if (w_hold_done) w_nxt = r_state + state_t'(1);
      ST_ENDING, ST_GAMEOVER:
        if (btn_start) w_nxt = ST_TITLE;
      default: w_nxt = ST_TITLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_TITLE;
      r_stage_num   <= 2'd0;
      r_stage_enter <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_stage_num   <= stage_of(w_nxt);
      r_stage_enter <= is_stage(w_nxt) && (w_nxt != r_state);
    end
  end

  assign state       = r_state;
  assign stage_num   = r_stage_num;
  assign stage_enter = r_stage_enter;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with CLEAR_HOLD_CYC=4, TIMEOUT_MIN=1.
module tb_game_flow_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0, btn_staff = 1'b0, stage_clear = 1'b0, player_dead = 1'b0;
  logic [15:0] time_bcd = 16'h0000;
  logic [3:0]  state;
  logic [1:0]  stage_num;
  logic        stage_enter;
  int          checks = 0;
  int          failures = 0;

  game_flow_ctrl #(.CLEAR_HOLD_CYC(4), .TIMEOUT_MIN(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_staff   (btn_staff),
    .stage_clear (stage_clear),
    .player_dead (player_dead),
    .time_bcd    (time_bcd),
    .state       (state),
    .stage_num   (stage_num),
    .stage_enter (stage_enter)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    btn_start = 0; btn_staff = 0; stage_clear = 0; player_dead = 0;
  endtask

  task automatic test_reset();
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (stage_num !== 2'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", stage_num); end
    checks++; if (stage_enter !== 1'b0) begin failures++; $display("FAIL reset_enter got=%0d exp=0", stage_enter); end
    tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (state !== 4'd0) begin failures++; $display("FAIL idle_title cyc=%0d got=%0d exp=0", i, state); end
    end
    btn_start = 1; tick(); btn_start = 0;
    checks++; if (state !== 4'd2) begin failures++; $display("FAIL start_state got=%0d exp=2", state); end
    checks++; if (stage_num !== 2'd1) begin failures++; $display("FAIL start_num got=%0d exp=1", stage_num); end
    checks++; if (stage_enter !== 1'b1) begin failures++; $display("FAIL start_enter got=%0d exp=1", stage_enter); end
    tick();
    checks++; if (stage_enter !== 1'b0 || state !== 4'd2) begin failures++; $display("FAIL enter_once enter=%0d state=%0d exp enter=0 state=2", stage_enter, state); end
  endtask

  task automatic test_clear_hold();
    stage_clear = 1; tick(); stage_clear = 0;
    checks++; if (state !== 4'd3 || stage_num !== 2'd1) begin failures++; $display("FAIL clear1_entry state=%0d num=%0d exp 3/1", state, stage_num); end
    for (int i = 0; i < 3; i++) begin
      btn_start = 1; btn_staff = 1; stage_clear = 1; player_dead = 1;
      tick();
      checks++; if (state !== 4'd3) begin failures++; $display("FAIL hold_ignore cyc=%0d got=%0d exp=3", i, state); end
    end
    clear_inputs(); tick();
    checks++; if (state !== 4'd4 || stage_enter !== 1'b1 || stage_num !== 2'd2) begin
      failures++; $display("FAIL stage2_entry state=%0d enter=%0d num=%0d exp 4/1/2", state, stage_enter, stage_num); end
    tick();
  endtask

  task automatic test_dead_priority();
    player_dead = 1; stage_clear = 1; tick(); clear_inputs();
    checks++; if (state !== 4'd8 || stage_num !== 2'd0) begin failures++; $display("FAIL dead_prio state=%0d num=%0d exp 8/0", state, stage_num); end
    btn_staff = 1; tick(); btn_staff = 0;
    checks++; if (state !== 4'd8) begin failures++; $display("FAIL gameover_staff got=%0d exp=8", state); end
    btn_start = 1; tick(); btn_start = 0;
    checks++; if (state !== 4'd0 || stage_num !== 2'd0) begin failures++; $display("FAIL gameover_start state=%0d num=%0d exp 0/0", state, stage_num); end
  endtask

  task automatic test_full_run();
    btn_staff = 1; tick(); btn_staff = 0;
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL staff got=%0d exp=1", state); end
    btn_staff = 1; tick(); btn_staff = 0;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL staff_back got=%0d exp=0", state); end
    btn_start = 1; btn_staff = 1; tick(); clear_inputs();
    checks++; if (state !== 4'd2) begin failures++; $display("FAIL start_wins got=%0d exp=2", state); end
    for (int s = 0; s < 2; s++) begin
      stage_clear = 1; tick(); stage_clear = 0;
      checks++; if (state !== 4'(3 + 2*s)) begin failures++; $display("FAIL run_clear s=%0d got=%0d exp=%0d", s, state, 3 + 2*s); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (state !== 4'(4 + 2*s) || stage_enter !== 1'b1 || stage_num !== 2'(2 + s)) begin
        failures++; $display("FAIL run_next s=%0d state=%0d enter=%0d num=%0d exp %0d/1/%0d", s, state, stage_enter, stage_num, 4 + 2*s, 2 + s); end
    end
    stage_clear = 1; tick(); stage_clear = 0;
    checks++; if (state !== 4'd7 || stage_num !== 2'd0) begin failures++; $display("FAIL ending state=%0d num=%0d exp 7/0", state, stage_num); end
    btn_staff = 1; tick(); btn_staff = 0;
    checks++; if (state !== 4'd7) begin failures++; $display("FAIL ending_staff got=%0d exp=7", state); end
    btn_start = 1; tick(); btn_start = 0;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL ending_start got=%0d exp=0", state); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_to;
`ifdef STAGE_TIMEOUT_EN
    exp_to = 4'd8;
`else
    exp_to = 4'd2;
`endif
    time_bcd = 16'h0159;
    btn_start = 1; tick(); btn_start = 0;
    tick(); tick();
    checks++; if (state !== 4'd2) begin failures++; $display("FAIL to_masked got=%0d exp=2", state); end
    time_bcd = 16'h0000; tick();
    checks++; if (state !== 4'd2) begin failures++; $display("FAIL to_zero got=%0d exp=2", state); end
    time_bcd = 16'h0100; tick();
    checks++; if (state !== exp_to) begin failures++; $display("FAIL to_expire got=%0d exp=%0d", state, exp_to); end
    time_bcd = 16'h0000;
    if (state == 4'd2) begin player_dead = 1; tick(); player_dead = 0; end
    btn_start = 1; tick(); btn_start = 0;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL to_return got=%0d exp=0", state); end
  endtask

  task automatic test_async_reset();
    btn_start = 1; tick(); btn_start = 0;
    stage_clear = 1; tick(); stage_clear = 0;
    for (int i = 0; i < 4; i++) tick();
    stage_clear = 1; tick(); stage_clear = 0;
    checks++; if (state !== 4'd5) begin failures++; $display("FAIL clear2_entry got=%0d exp=5", state); end
    tick(); tick();
    #2 rst_n = 0;
    #1;
    checks++; if (state !== 4'd0 || stage_num !== 2'd0) begin failures++; $display("FAIL async_rst state=%0d num=%0d exp 0/0", state, stage_num); end
    tick(); rst_n = 1;
    btn_start = 1; tick(); btn_start = 0;
    checks++; if (state !== 4'd2) begin failures++; $display("FAIL post_rst_start got=%0d exp=2", state); end
    stage_clear = 1; tick(); stage_clear = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== 4'd3) begin failures++; $display("FAIL fresh_hold cyc=%0d got=%0d exp=3", i, state); end
      tick();
    end
    checks++; if (state !== 4'd3) begin failures++; $display("FAIL fresh_hold_last got=%0d exp=3", state); end
    tick();
    checks++; if (state !== 4'd4) begin failures++; $display("FAIL fresh_hold_exit got=%0d exp=4", state); end
  endtask

  initial begin
    #2;
    test_reset();
    test_clear_hold();
    test_dead_priority();
    test_full_run();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer that generates the 4-bit `state` code consumed by the stage timer and every other state-driven block in the design. It advances from the title screen through three stages and the between-stage clear screens, then to the ending or game-over screens. Transitions come from button pulses, gameplay events, a clear-screen hold timer and an optional stage time limit.

## Interface
- `CLEAR_HOLD_CYC`, default 200_000_000: clear-screen dwell in clock cycles (2 s at 100 MHz); must be ≥ 1.
- `TIMEOUT_MIN`, default 5: stage time limit in whole minutes, range 1–99; used only with `STAGE_TIMEOUT_EN`.
- `clk`, input, 1: system clock, 100 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_start`, input, 1: one-cycle pulse, already debounced upstream.
- `btn_staff`, input, 1: one-cycle pulse, already debounced upstream.
- `stage_clear`, input, 1: one-cycle pulse from the gameplay logic.
- `player_dead`, input, 1: one-cycle pulse from the gameplay logic.
- `time_bcd`, input, 16: `{min_10, min_1, sec_10, sec_1}` BCD digits from the stage timer, i.e. its `nums[15:0]`.
- `state`, output, 4: current state code.
- `stage_num`, output, 2: 1–3 while in STAGEn or CLEARn; 0 otherwise.
- `stage_enter`, output, 1: one-cycle pulse in the first cycle `state` holds a STAGE code.

## Operation
- State codes:
  - TITLE = 0, STAFF = 1
  - STAGE1 = 2, CLEAR1 = 3
  - STAGE2 = 4, CLEAR2 = 5
  - STAGE3 = 6
  - ENDING = 7, GAMEOVER = 8
  - Codes 9–15 are unused; if reached, the next cycle goes to TITLE.
- TITLE:
  - `btn_start` → STAGE1.
  - Otherwise `btn_staff` → STAFF.
  - If both pulse in the same cycle, `btn_start` wins.
- STAFF: `btn_start` or `btn_staff` → TITLE.
- STAGEn, evaluated in priority order:
  1. `player_dead` → GAMEOVER.
  2. Timeout (only with the macro) → GAMEOVER.
  3. `stage_clear` → CLEARn for n = 1, 2, or → ENDING for n = 3.
- CLEARn:
  - Hold counter loads 0 on entry and increments each cycle.
  - When the count reaches `CLEAR_HOLD_CYC - 1`, the next state is STAGE(n+1).
  - All inputs are ignored in this state.
- ENDING and GAMEOVER: `btn_start` → TITLE; all other inputs are ignored.
- Hold counter:
  - Width is `$clog2(CLEAR_HOLD_CYC+1)`.
  - Held at 0 outside CLEARn.
- `stage_num` and `stage_enter` are registered and derived from the next-state value, so they align with `state`.

## Timing
- Reset values: `state` = TITLE, `stage_num` = 0, `stage_enter` = 0, hold counter = 0.
- Reset takes effect asynchronously; the first transition can occur on the first `clk` edge after `rst_n` rises.
- Reset asserted in any state, including mid-hold, returns to TITLE immediately; the hold count is discarded.
- Event latency: a pulse sampled at edge k makes `state` change at edge k.
  - Visible one cycle after the pulse is presented.
  - No buffering: a pulse that arrives in a state which ignores it is lost.
- CLEARn dwell is exactly `CLEAR_HOLD_CYC` cycles with `state` = CLEARn.
- `stage_enter` is high for exactly one cycle per STAGE entry, coincident with the first cycle of the STAGE code.

## Configuration
- `STAGE_TIMEOUT_EN` defined:
  - In STAGEn, timeout is `10*time_bcd[15:12] + time_bcd[11:8] >= TIMEOUT_MIN`.
  - The check is masked for the first 2 cycles of every STAGE entry. The timer's displayed value lags the state by up to 2 cycles and may still hold the previous stage's time.
  - Mask counter is 2 bits and saturates.
- `STAGE_TIMEOUT_EN` undefined:
  - `time_bcd` is unused.
  - No comparator or mask logic is built; stages never time out.

## Structure
- Shared package `game_pkg`:
  - State code localparams, shared with the timer and display blocks.
  - `STATE_W = 4`.
- One sub-module `hold_timer`:
  - Ports: `clk`, `rst_n`, `clr`, `en` in; `done` out.
  - `done` is high when the count equals `CLEAR_HOLD_CYC - 1`.
  - Parameterised by `CLEAR_HOLD_CYC`.
- The FSM and output registers stay in `game_flow_ctrl`.

## Test plan
All scenarios use `CLEAR_HOLD_CYC` = 4 and `TIMEOUT_MIN` = 1.

- Reset, then `btn_start` at cycle 5 → `state` 0 until the edge, then 2; `stage_num` = 1; `stage_enter` high for exactly 1 cycle.
- STAGE1 + `stage_clear` → `state` 3 for exactly 4 cycles → `state` 4 with a `stage_enter` pulse; inputs pulsed during the hold are ignored.
- STAGE2 with `player_dead` and `stage_clear` in the same cycle → `state` 8; then `btn_start` → `state` 0, `stage_num` = 0.
- Full run STAGE1 → 3 → 4 → 5 → 6; `stage_clear` in STAGE3 → `state` 7; `btn_staff` in ENDING → no change; `btn_start` → `state` 0.
- With `STAGE_TIMEOUT_EN`: enter STAGE1 with `time_bcd` = 0x0159.
  - No timeout in the first 2 cycles.
  - `time_bcd` = 0x0000, then 0x0100 → `state` 8 on the next edge.
  - Without the macro, the same stimulus keeps `state` = 2.
- `rst_n` low mid-CLEAR2 (count = 2) → `state` 0 asynchronously; after release, `btn_start` → STAGE1 with a fresh 4-cycle hold on the next clear.
